// File: rtl/store_buffer_if.sv
// Bundles the signals between the MEM stage, the store buffer and data memory.
//   Pipeline side : mem_adr, write_data, mem_read, mem_write -> buffer
//                   read_data, stall, buf_empty               <- buffer
//   Memory side   : dm_adr, dm_write_data, dm_read, dm_write  <- buffer
//                   dm_read_data                              -> buffer
// Modports: slave = the store buffer, master = its environment (pipeline + memory).
interface store_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] write_data;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] read_data;
  logic          stall;
  logic          buf_empty;
  logic [AW-1:0] dm_adr;
  logic [DW-1:0] dm_write_data;
  logic          dm_read;
  logic          dm_write;
  logic [DW-1:0] dm_read_data;

  modport slave (
    input  mem_adr, write_data, mem_read, mem_write, dm_read_data,
    output read_data, stall, buf_empty, dm_adr, dm_write_data, dm_read, dm_write
  );

  modport master (
    output mem_adr, write_data, mem_read, mem_write, dm_read_data,
    input  read_data, stall, buf_empty, dm_adr, dm_write_data, dm_read, dm_write
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory.
// Pending stores sit in a circular FIFO and drain into data memory whenever the
// port is not claimed by a load. Loads are checked against pending entries by
// word address so they never observe stale memory.
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_ni - asynchronous active-low reset; discards all pending stores
//   bus    - store_buffer_if.slave (pipeline request/response + data memory port)
// Build option: define STORE_BUF_FWD_EN to forward the youngest matching buffered
// store to a load; otherwise a matching load stalls until its entries drain.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input logic          clk_i,
  input logic          rst_ni,
  store_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [AW-1:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic          full, empty;
  logic          match;
  logic [DW-1:0] hit_data;
  logic [PtrW-1:0] idx;
  logic          is_load, is_store;
  logic          load_stall, load_fwd;
  logic          port_read, drain, push;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    match    = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if (valid_q[idx] && (addr_q[idx][AW-1:2] == bus.mem_adr[AW-1:2])) begin
        match    = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // A simultaneous read+write request is treated as a store.
  assign is_store = bus.mem_write;
  assign is_load  = bus.mem_read & ~bus.mem_write;

`ifdef STORE_BUF_FWD_EN
  assign load_stall = 1'b0;
  assign load_fwd   = is_load & match;
`else
  assign load_stall = is_load & match;
  assign load_fwd   = 1'b0;
`endif

  // The read request keeps the port unless the load is served from the buffer
  // or has to wait for matching stores to drain.
  assign port_read = bus.mem_read & ~load_stall & ~load_fwd;
  assign drain     = ~port_read & ~empty;
  assign push      = is_store & ~full;

  always_comb begin
    bus.stall         = 1'b0;
    bus.read_data     = '0;
    bus.dm_read       = 1'b0;
    bus.dm_write      = 1'b0;
    bus.dm_adr        = '0;
    bus.dm_write_data = '0;
    bus.buf_empty     = empty;
    if (!rst_ni) begin
      // Outputs held quiet while reset is asserted.
      bus.buf_empty = 1'b1;
    end else begin
      bus.stall = (is_store & full) | load_stall;
      if (port_read) begin
        bus.dm_read = 1'b1;
        bus.dm_adr  = bus.mem_adr;
      end else if (drain) begin
        bus.dm_write      = 1'b1;
        bus.dm_adr        = addr_q[rd_ptr_q];
        bus.dm_write_data = data_q[rd_ptr_q];
      end
      if (load_fwd) begin
        bus.read_data = hit_data;
      end else if (is_load && !load_stall) begin
        bus.read_data = bus.dm_read_data;
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (drain) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    unique case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; valid_q qualifies every entry.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.mem_adr;
      data_q[wr_ptr_q] <= bus.write_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  string cur;

  ent_t          q[$];
  logic [DW-1:0] ref_mem [1024];
  logic          last_stall;

  store_buffer_if #(.AW(AW), .DW(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: commits on the falling edge, reads combinationally.
  bit [DW-1:0] mem [1024];
  bit          mw  [1024];

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    return 32'hA500_0000 | i;
  endfunction

  always @(negedge clk) begin
    if (bus.dm_write) begin
      mem[bus.dm_adr[11:2]] <= bus.dm_write_data;
      mw[bus.dm_adr[11:2]]  <= 1'b1;
    end
  end

  assign bus.dm_read_data = mw[bus.dm_adr[11:2]] ? mem[bus.dm_adr[11:2]]
                                                 : init_word(32'(bus.dm_adr[11:2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s [%s]: got %0h want %0h", tag, cur, obs, exp);
    end
  endtask

  // One clock cycle: apply a request, predict from the model, compare, update.
  task automatic step(input string tag, input logic rd, input logic wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic          e_stall, e_dr, e_dw, e_empty, e_chk_rd, m;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wd, e_rdata, hit;
    @(posedge clk);
    #1;
    cur            = tag;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.mem_adr    = a;
    bus.write_data = d;
    m   = 1'b0;
    hit = '0;
    foreach (q[i]) begin
      if (q[i].a[AW-1:2] == a[AW-1:2]) begin
        m   = 1'b1;
        hit = q[i].d;
      end
    end
    e_stall  = 1'b0;
    e_dr     = 1'b0;
    e_dw     = 1'b0;
    e_adr    = '0;
    e_wd     = '0;
    e_rdata  = '0;
    e_chk_rd = 1'b1;
    e_empty  = (q.size() == 0);
    if (wr) begin
      e_stall = (q.size() == DEPTH);
      if (rd) begin
        e_dr  = 1'b1;
        e_adr = a;
      end
    end else if (rd) begin
      if (!m) begin
        e_dr    = 1'b1;
        e_adr   = a;
        e_rdata = ref_mem[a[11:2]];
      end else if (FWD) begin
        e_rdata = hit;
      end else begin
        e_stall  = 1'b1;
        e_chk_rd = 1'b0;
      end
    end
    if (!e_dr && q.size() > 0) begin
      e_dw  = 1'b1;
      e_adr = q[0].a;
      e_wd  = q[0].d;
    end
    #2;
    chk("stall", 64'(bus.stall), 64'(e_stall));
    chk("dm_read", 64'(bus.dm_read), 64'(e_dr));
    chk("dm_write", 64'(bus.dm_write), 64'(e_dw));
    chk("dm_adr", 64'(bus.dm_adr), 64'(e_adr));
    chk("buf_empty", 64'(bus.buf_empty), 64'(e_empty));
    if (e_chk_rd) chk("read_data", 64'(bus.read_data), 64'(e_rdata));
    if (e_dw) chk("dm_write_data", 64'(bus.dm_write_data), 64'(e_wd));
    if (e_dw) begin
      ref_mem[q[0].a[11:2]] = q[0].d;
      void'(q.pop_front());
    end
    if (wr && !e_stall) q.push_back('{a: a, d: d});
    last_stall = e_stall;
  endtask

  initial begin
    logic          rd, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned   r;
    total      = 0;
    bad        = 0;
    last_stall = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(32'(i));

    // Reset with a store request present.
    rst_n          = 1'b1;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b1;
    bus.mem_adr    = 32'h0000_0400;
    bus.write_data = 32'h1234_5678;
    #1 rst_n = 1'b0;
    #3;
    cur = "reset";
    chk("rst_buf_empty", 64'(bus.buf_empty), 64'd1);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_dm_write", 64'(bus.dm_write), 64'd0);
    chk("rst_dm_read", 64'(bus.dm_read), 64'd0);
    chk("rst_dm_adr", 64'(bus.dm_adr), 64'd0);
    chk("rst_read_data", 64'(bus.read_data), 64'd0);
    @(negedge clk);
    bus.mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle_after_reset", 1'b0, 1'b0, '0, '0);

    // Single store then idle.
    step("single_store", 1'b0, 1'b1, 32'h0000_040C, 32'hDEAD_BEEF);
    step("single_drain", 1'b0, 1'b0, '0, '0);
    step("single_empty", 1'b0, 1'b0, '0, '0);

    // Fill with the port held by memRead, then overflow.
    for (int i = 0; i < 4; i++)
      step("fill", 1'b1, 1'b1, 32'h0000_0400 + 32'(4 * i), 32'hF000_0000 + 32'(i));
    step("overflow_held", 1'b1, 1'b1, 32'h0000_0410, 32'hF000_0004);
    step("overflow_drain", 1'b0, 1'b1, 32'h0000_0410, 32'hF000_0004);
    step("overflow_enq", 1'b0, 1'b1, 32'h0000_0410, 32'hF000_0004);
    for (int i = 0; i < 5; i++) step("fill_drain", 1'b0, 1'b0, '0, '0);

    // Load priority over pending stores.
    step("prio_st0", 1'b1, 1'b1, 32'h0000_0600, 32'h0000_AAAA);
    step("prio_st1", 1'b1, 1'b1, 32'h0000_0604, 32'h0000_BBBB);
    step("prio_load", 1'b1, 1'b0, 32'h0000_0500, '0);
    for (int i = 0; i < 3; i++) step("prio_drain", 1'b0, 1'b0, '0, '0);

    // Load hitting two buffered stores to the same word.
    step("fwd_st0", 1'b1, 1'b1, 32'h0000_0404, 32'h0000_0011);
    step("fwd_st1", 1'b1, 1'b1, 32'h0000_0404, 32'h0000_0022);
    for (int i = 0; i < 3; i++) step("fwd_load", 1'b1, 1'b0, 32'h0000_0406, '0);
    for (int i = 0; i < 2; i++) step("fwd_idle", 1'b0, 1'b0, '0, '0);

    // Reset asserted while stores are draining.
    for (int i = 0; i < 3; i++)
      step("pre_rst", 1'b1, 1'b1, 32'h0000_0700 + 32'(4 * i), 32'hC000_0000 + 32'(i));
    @(posedge clk);
    #1;
    cur           = "mid_drain_reset";
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    #1;
    chk("drain_active", 64'(bus.dm_write), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dm_write", 64'(bus.dm_write), 64'd0);
    chk("rst_mid_empty", 64'(bus.buf_empty), 64'd1);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle_after_mid_reset", 1'b0, 1'b0, '0, '0);

    // Random traffic; a stalled request is re-issued like a frozen pipeline.
    rd = 1'b0;
    wr = 1'b0;
    a  = '0;
    d  = '0;
    for (int n = 0; n < 400; n++) begin
      if (!(last_stall && !(rd && wr))) begin
        r  = $urandom_range(0, 9);
        rd = (r >= 4 && r <= 6) || (r == 9);
        wr = (r <= 3) || (r == 9);
        a  = 32'h0000_0700 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
        d  = $urandom;
      end
      step("random", rd, wr, a, d);
    end
    for (int i = 0; i < 6; i++) step("final_drain", 1'b0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
